// File: rtl/vita49_pack_logic_if.sv
// rtl/vita49_pack_logic_if.sv - 64-bit stream bundle shared by the framer input and output
interface vita49_pack_logic_if;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/vita49_pack_logic.sv
// rtl/vita49_pack_logic.sv - transmit VITA-49 framer: header insert, fixed-size cut, zero pad
module vita49_pack_logic #(
    parameter int MAX_BEATS = 32766
) (
    input  logic                       AXIS_ACLK,
    input  logic                       AXIS_ARESETN,
    vita49_pack_logic_if.slave         s_axis,
    vita49_pack_logic_if.master        m_axis,
    input  logic [31:0]                ctrl,
    input  logic [31:0]                strm_id,
    output logic [15:0]                short_pkt_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, PASS} state_t;

    state_t      state, state_nx;
    logic        full, tlast_reg;
    logic [63:0] tdata_reg;
    logic [14:0] n_beats, beat_cnt, n_clamp;
    logic [3:0]  pkt_cnt;
    logic [31:0] hdr_id;
    logic [15:0] pkt_size;
    logic        start, reset_cmd, passthrough;
    logic        m_fire, s_fire, drain, last_beat, hdr_load;
    logic        unused_ctrl;

    assign start       = ctrl[0];
    assign reset_cmd   = ctrl[1];
    assign passthrough = ctrl[2];
    assign unused_ctrl = ^ctrl[15:3];

    always_comb begin
        if (ctrl[31:16] == 16'd0)
            n_clamp = 15'd1;
        else if (ctrl[31:16] > 16'(MAX_BEATS))
            n_clamp = 15'(MAX_BEATS);
        else
            n_clamp = ctrl[30:16];
    end

    assign pkt_size  = 16'd2 + {n_beats, 1'b0};
    assign last_beat = (beat_cnt == n_beats - 15'd1);
    assign m_fire    = m_axis.tvalid & m_axis.tready;
    assign s_fire    = s_axis.tvalid & s_axis.tready;

    // A held beat may be replaced in the same cycle it drains, giving 1 beat/cycle.
    assign s_axis.tready = (state != PAD) & ~reset_cmd & (~full | drain);
    assign m_axis.tstrb  = 8'hff;

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 64'd0;
        m_axis.tlast  = 1'b0;
        drain         = 1'b0;
        hdr_load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = passthrough ? PASS : HDR;
                    hdr_load = ~passthrough;
                end
            end
            HDR: begin
                // Header waits for a held payload beat so no empty packet is framed.
                m_axis.tvalid = full;
                m_axis.tdata  = {hdr_id, 4'b0001, 8'h00, pkt_cnt, pkt_size};
                if (m_fire)
                    state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                m_axis.tvalid = full;
                m_axis.tdata  = tdata_reg;
                m_axis.tlast  = last_beat;
                drain         = m_fire;
                if (m_fire) begin
                    if (last_beat) begin
                        state_nx = HDR;
                        hdr_load = 1'b1;
                    end else if (tlast_reg) begin
                        state_nx = PAD;
                    end
                end
            end
            PAD: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = last_beat;
                if (m_fire && last_beat) begin
                    state_nx = HDR;
                    hdr_load = 1'b1;
                end
            end
            PASS: begin
                m_axis.tvalid = full;
                m_axis.tdata  = tdata_reg;
                m_axis.tlast  = tlast_reg;
                drain         = m_fire;
            end
            default: state_nx = IDLE;
        endcase
        if (reset_cmd) begin
            state_nx = IDLE;
            hdr_load = 1'b0;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            full          <= 1'b0;
            tdata_reg     <= 64'd0;
            tlast_reg     <= 1'b0;
            n_beats       <= 15'd1;
            hdr_id        <= 32'd0;
            beat_cnt      <= 15'd0;
            pkt_cnt       <= 4'd0;
            short_pkt_cnt <= 16'd0;
        end else begin
            if (reset_cmd) begin
                full <= 1'b0;
            end else if (s_fire) begin
                full      <= 1'b1;
                tdata_reg <= s_axis.tdata;
                tlast_reg <= s_axis.tlast;
            end else if (drain) begin
                full <= 1'b0;
            end

            if (hdr_load) begin
                n_beats <= n_clamp;
                hdr_id  <= strm_id;
            end

            if (state == HDR && m_fire)
                beat_cnt <= 15'd0;
            else if ((state == PAYLOAD || state == PAD) && m_fire && !last_beat)
                beat_cnt <= beat_cnt + 15'd1;

            if (state == IDLE) begin
                pkt_cnt       <= 4'd0;
                short_pkt_cnt <= 16'd0;
            end else if ((state == PAYLOAD || state == PAD) && m_fire && last_beat) begin
                pkt_cnt <= pkt_cnt + 4'd1;
                if (state == PAD && short_pkt_cnt != 16'hffff)
                    short_pkt_cnt <= short_pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vita49_pack_logic.sv
// tb/tb_vita49_pack_logic.sv - randomized self-checking bench for the VITA-49 framer
module tb_vita49_pack_logic;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] ctrl = 32'd0;
    logic [31:0] strm_id = 32'd0;
    logic [15:0] short_pkt_cnt;

    vita49_pack_logic_if s_if ();
    vita49_pack_logic_if m_if ();

    vita49_pack_logic #(.MAX_BEATS(32766)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (resetn),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .ctrl          (ctrl),
        .strm_id       (strm_id),
        .short_pkt_cnt (short_pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] in_data[$];
    logic        in_last[$];
    logic [63:0] out_data[$];
    logic        out_last[$];
    int          out_cyc[$];
    logic        out_sready[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];
    int          exp_short;

    function automatic int clamp_n(input logic [15:0] c);
        if (c == 16'd0) return 1;
        if (int'(c) > 32766) return 32766;
        return int'(c);
    endfunction

    // Reference framing: header, then N slots filled from input until a burst ends, rest zero.
    function automatic void build_expected(input int nb, input logic [31:0] sid, input bit pass);
        int i;
        int pkt;
        bit ended;
        bit padded;
        logic [15:0] psize;
        logic [3:0]  pc;
        exp_data.delete();
        exp_last.delete();
        exp_short = 0;
        if (pass) begin
            foreach (in_data[k]) begin
                exp_data.push_back(in_data[k]);
                exp_last.push_back(in_last[k]);
            end
            return;
        end
        i = 0;
        pkt = 0;
        psize = 16'(2 + 2 * nb);
        while (i < in_data.size()) begin
            pc = 4'(pkt % 16);
            exp_data.push_back({sid, 4'h1, 8'h00, pc, psize});
            exp_last.push_back(1'b0);
            ended = 0;
            padded = 0;
            for (int k = 0; k < nb; k++) begin
                if (!ended && i < in_data.size()) begin
                    exp_data.push_back(in_data[i]);
                    ended = in_last[i];
                    i++;
                end else begin
                    exp_data.push_back(64'd0);
                    padded = 1;
                end
                exp_last.push_back(k == nb - 1);
            end
            if (padded) exp_short++;
            pkt++;
        end
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        ctrl = 32'd0;
        s_if.tvalid = 1'b0;
        s_if.tdata = 64'd0;
        s_if.tlast = 1'b0;
        s_if.tstrb = 8'hff;
        m_if.tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run_stream(input int vprob, input int rprob, input int n_exp,
                              input int max_cyc, input string name);
        int idx;
        int cyc;
        bit pend;
        bit stalled;
        logic [63:0] prev;
        idx = 0;
        cyc = 0;
        pend = 0;
        stalled = 0;
        prev = 64'd0;
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
        out_sready.delete();
        while (out_data.size() < n_exp && cyc < max_cyc) begin
            @(negedge clk);
            if (!pend) begin
                if (idx < in_data.size() && $urandom_range(99) < vprob) begin
                    s_if.tvalid = 1'b1;
                    s_if.tdata  = in_data[idx];
                    s_if.tlast  = in_last[idx];
                end else begin
                    s_if.tvalid = 1'b0;
                    s_if.tdata  = 64'd0;
                    s_if.tlast  = 1'b0;
                end
            end
            m_if.tready = ($urandom_range(99) < rprob);
            #1;
            if (stalled) begin
                n_vec++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev) begin
                    n_err++;
                    $display("FAIL %s stall_hold: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                             name, m_if.tvalid, m_if.tdata, prev);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                out_data.push_back(m_if.tdata);
                out_last.push_back(m_if.tlast);
                out_cyc.push_back(cyc);
                out_sready.push_back(s_if.tready);
            end
            stalled = m_if.tvalid && !m_if.tready;
            prev = m_if.tdata;
            if (s_if.tvalid && s_if.tready) begin
                idx++;
                pend = 0;
            end else begin
                pend = s_if.tvalid;
            end
            cyc++;
        end
        n_vec++;
        if (out_data.size() < n_exp) begin
            n_err++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, out_data.size(), n_exp);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ctrl = 32'd0;
        s_if.tvalid = 1'b0;
        s_if.tstrb = 8'hff;
        m_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 ||
            m_if.tdata !== 64'd0 || short_pkt_cnt !== 16'd0 || m_if.tstrb !== 8'hff) begin
            n_err++;
            $display("FAIL reset_state: sready=%b mvalid=%b mlast=%b mdata=%h short=%h strb=%h, required 1 0 0 0 0 ff",
                     s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, short_pkt_cnt, m_if.tstrb);
        end
        resetn = 1'b1;
    endtask

    task automatic test_contiguous();
        apply_reset();
        strm_id = 32'hCAFE0001;
        ctrl = {16'd4, 16'h0001};
        in_data.delete();
        in_last.delete();
        for (int i = 0; i < 12; i++) begin
            in_data.push_back({$urandom, $urandom});
            in_last.push_back(1'b0);
        end
        build_expected(4, strm_id, 0);
        run_stream(100, 100, 15, 200, "contiguous");
        for (int i = 0; i < 15 && i < out_data.size(); i++) begin
            n_vec++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL contiguous beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
            end
        end
        if (out_data.size() == 15) begin
            n_vec++;
            if (out_data[10][31:0] !== 32'h1002000A) begin
                n_err++;
                $display("FAIL contiguous hdr3: %h, required 1002000a", out_data[10][31:0]);
            end
            n_vec++;
            if (out_cyc[14] - out_cyc[0] != 14) begin
                n_err++;
                $display("FAIL contiguous gapless: span=%0d, required 14", out_cyc[14] - out_cyc[0]);
            end
        end
    endtask

    task automatic test_short_pad();
        apply_reset();
        strm_id = $urandom;
        ctrl = {16'd4, 16'h0001};
        in_data = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        in_last = '{1'b0, 1'b1};
        build_expected(4, strm_id, 0);
        run_stream(100, 100, 5, 200, "short_pad");
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            n_vec++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL short_pad beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
            end
            if (i >= 3) begin
                n_vec++;
                if (out_sready[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL short_pad sready_pad%0d: %b, required 0", i, out_sready[i]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (short_pkt_cnt !== 16'(exp_short)) begin
            n_err++;
            $display("FAIL short_pad short_cnt: %0d, required %0d", short_pkt_cnt, exp_short);
        end
    endtask

    task automatic test_random();
        apply_reset();
        strm_id = $urandom;
        ctrl = {16'd2, 16'h0001};
        in_data.delete();
        in_last.delete();
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(7) == 0) begin
                in_data.push_back({$urandom, $urandom});
                in_last.push_back(1'b1);
            end else begin
                in_data.push_back({$urandom, $urandom});
                in_last.push_back(1'b0);
                in_data.push_back({$urandom, $urandom});
                in_last.push_back(1'($urandom_range(1)));
            end
        end
        build_expected(2, strm_id, 0);
        run_stream(60, 50, exp_data.size(), 6000, "random");
        n_vec++;
        if (out_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL random count: %0d, required %0d", out_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_vec++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL random beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
            end
        end
        if (out_data.size() > 48) begin
            n_vec++;
            if (out_data[48][19:16] !== 4'd0) begin
                n_err++;
                $display("FAIL random wrap17: pkt_cnt=%0d, required 0", out_data[48][19:16]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (short_pkt_cnt !== 16'(exp_short)) begin
            n_err++;
            $display("FAIL random short_cnt: %0d, required %0d", short_pkt_cnt, exp_short);
        end
    endtask

    task automatic test_size_bounds();
        apply_reset();
        strm_id = $urandom;
        ctrl = {16'd0, 16'h0001};
        in_data.delete();
        in_last.delete();
        for (int i = 0; i < 3; i++) begin
            in_data.push_back({$urandom, $urandom});
            in_last.push_back(1'($urandom_range(1)));
        end
        build_expected(clamp_n(16'd0), strm_id, 0);
        run_stream(100, 100, 6, 200, "size_min");
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            n_vec++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL size_min beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
            end
        end
        apply_reset();
        ctrl = {16'hFFFF, 16'h0001};
        in_data = '{64'h0123_4567_89AB_CDEF};
        in_last = '{1'b0};
        run_stream(100, 100, 2, 100, "size_max");
        if (out_data.size() >= 1) begin
            n_vec++;
            if (out_data[0] !== {strm_id, 32'h1000FFFE}) begin
                n_err++;
                $display("FAIL size_max hdr: %h, required %h", out_data[0], {strm_id, 32'h1000FFFE});
            end
        end
    endtask

    task automatic test_reset_cmd();
        apply_reset();
        strm_id = $urandom;
        ctrl = {16'd8, 16'h0001};
        in_data.delete();
        in_last.delete();
        for (int i = 0; i < 16; i++) begin
            in_data.push_back({$urandom, $urandom});
            in_last.push_back(1'b0);
        end
        run_stream(100, 100, 11, 200, "reset_cmd_pre");
        @(negedge clk);
        n_vec++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== in_data[9]) begin
            n_err++;
            $display("FAIL reset_cmd beat1: valid=%b data=%h, required 1 %h", m_if.tvalid, m_if.tdata, in_data[9]);
        end
        ctrl = {16'd8, 16'h0002};
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_if.tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cmd idle_valid: %b, required 0", m_if.tvalid);
        end
        ctrl = {16'd8, 16'h0001};
        in_data = '{64'hDEAD_BEEF_0000_0001};
        in_last = '{1'b0};
        run_stream(100, 100, 1, 100, "reset_cmd_post");
        if (out_data.size() >= 1) begin
            n_vec++;
            if (out_data[0] !== {strm_id, 32'h10000012}) begin
                n_err++;
                $display("FAIL reset_cmd new_hdr: %h, required %h", out_data[0], {strm_id, 32'h10000012});
            end
        end
    endtask

    task automatic test_passthrough();
        apply_reset();
        strm_id = $urandom;
        ctrl = {16'd4, 16'h0005};
        in_data.delete();
        in_last.delete();
        for (int i = 0; i < 3; i++) begin
            in_data.push_back({$urandom, $urandom});
            in_last.push_back(i == 2);
        end
        build_expected(4, strm_id, 1);
        run_stream(100, 100, 3, 100, "passthrough");
        for (int i = 0; i < 3 && i < out_data.size(); i++) begin
            n_vec++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL passthrough beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = 64'd0;
        s_if.tlast = 1'b0;
        s_if.tstrb = 8'hff;
        m_if.tready = 1'b0;
        test_reset();
        test_contiguous();
        test_short_pad();
        test_random();
        test_size_bounds();
        test_reset_cmd();
        test_passthrough();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vita49_pack_logic.md
Name: vita49_pack_logic

Overview:
- Transmit-side VITA-49 framer. Takes a raw 64-bit sample stream (two 32-bit words per beat) and prepends a one-beat VITA-49 header: header word in [31:0], stream ID in [63:32].
- Cuts the stream into fixed-size packets and generates TLAST from the programmed size.
- Pads short input bursts with zeros so every emitted packet matches the size stated in its header.
- Sits upstream of the DMA/link path and is the counterpart of the receive-side header checker.

Parameters:
- MAX_BEATS, 32766, upper clamp on payload beats per packet, so pkt_size = 2+2*beats fits in 16 bits.

Ports:
- AXIS_ACLK  in  1  clock
- AXIS_ARESETN  in  1  synchronous active-low reset
- S_AXIS_TDATA  in  64  raw sample data
- S_AXIS_TLAST  in  1  end of input burst
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA  out  64  framed VITA data
- M_AXIS_TSTRB  out  8  always 8'hff
- M_AXIS_TLAST  out  1  last beat of packet
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- ctrl  in  32  [0] start, [1] reset_cmd, [2] passthrough, [31:16] payload beats per packet
- strm_id  in  32  stream identifier
- short_pkt_cnt  out  16  saturating count of zero-padded packets

Behaviour:
- Reset: one clock, synchronous, active-low. Reset is sampled on AXIS_ACLK; AXIS_ARESETN=0 clears all state.
  - All registers clear; state = IDLE; holding register empty.
  - S_AXIS_TREADY=1, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, short_pkt_cnt=0.
- Input stage: one-entry holding register (tdata_reg, tlast_reg, full flag).
  - S_AXIS_TREADY = !full | (drain of the register this cycle).
  - A beat accepted in cycle k is presentable on M_AXIS in cycle k+1. Sustained rate is 1 beat/cycle.
- AXI rules: M_AXIS_TVALID never drops and M_AXIS_TDATA never changes without a transfer (M_AXIS_TVALID & M_AXIS_TREADY).
- Header word:
  - [31:28]=4'b0001; [27:20]=0 (c, t, reserved, tsi, tsf).
  - [19:16]=pkt_cnt; [15:0]=pkt_size = 2+2*N.
  - N is latched on entry to HDR: ctrl[31:16] clamped to [1, MAX_BEATS]; a value of 0 is treated as 1.
- States:
  - IDLE:
    - pkt_cnt=0; short_pkt_cnt=0; M_AXIS_TVALID=0.
    - Holding register still fills one beat.
    - Latches passthrough. start=1 -> HDR.
  - HDR:
    - M_AXIS_TVALID = full. The header is emitted only once a payload beat is held, so no empty packets are produced.
    - TDATA = {strm_id, header}; TLAST=0; the holding register is not drained.
    - On transfer: beat_cnt=0 -> PAYLOAD.
  - PAYLOAD:
    - TVALID = full; TDATA = tdata_reg; the register drains on transfer.
    - TLAST = (beat_cnt == N-1).
    - On transfer with beat_cnt==N-1: pkt_cnt++ (wraps 15->0) -> HDR. Any input tlast on that beat is ignored.
    - On transfer with tlast_reg=1 and beat_cnt<N-1: -> PAD.
    - Otherwise on transfer: beat_cnt++.
  - PAD:
    - S_AXIS_TREADY=0. TVALID=1; TDATA=0; TLAST = (beat_cnt == N-1).
    - beat_cnt++ per transfer.
    - On the final transfer: pkt_cnt++, short_pkt_cnt++ (saturates at 16'hffff) -> HDR.
- Passthrough (latched in IDLE): no header, no counting.
  - M_AXIS mirrors the holding register; TLAST = tlast_reg.
  - The state machine stays in PASS until reset_cmd.
- reset_cmd=1: next state IDLE, holding register flushed.
  - Takes priority over all transitions.
  - A packet in flight is truncated without TLAST; the downstream receiver recovers by header check.
- ctrl[31:16] changes take effect only at the next HDR entry.

Test Plan:
- N=4, strm_id=32'hCAFE0001, 12 contiguous beats, M_AXIS_TREADY=1 -> three packets, each 5 beats. Header [31:0] = 32'h1000000A / 32'h1001000A / 32'h1002000A. TLAST on beats 5, 10 and 15; no idle cycles after the first.
- N=4, 2 beats with TLAST on the 2nd -> header, 2 data beats, 2 zero beats with TLAST on the last; short_pkt_cnt=1; S_AXIS_TREADY=0 during pad.
- N=2, random M_AXIS_TREADY 50%, random S_AXIS_TVALID, 100 packets -> no beat lost or duplicated; TDATA stable while stalled. pkt_cnt wraps 15->0 at packet 17.
- ctrl[31:16]=0 -> pkt_size=4, 2-beat packets; ctrl[31:16]=16'hFFFF -> pkt_size=16'hFFFE.
- reset_cmd asserted in PAYLOAD at beat 1 of N=8 -> next cycle IDLE, TVALID=0; after start, the new packet header carries pkt_cnt=0.
- passthrough=1, 3 beats with TLAST on the 3rd -> output is identical to the input, no header, TLAST on the 3rd beat.
